piso_serializer: RTL and testbench



---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 85 ++++++++
 tb/tb_piso_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-side handshake and serial output bundle for piso_serializer.
// slave: the serializer. master: the upstream word source / downstream observer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last_bit;
  logic             busy;

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, last_bit, busy
  );

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, last_bit, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. A word is accepted on a valid/ready
// handshake and its bits appear on sout one per clock, first bit on the cycle
// right after the accept edge. The next word may be accepted on the last-bit
// cycle so consecutive words stream with no idle gap.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  piso_serializer_if.slave       bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_last;

  logic             w_ready;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_shifted;

  // Ready in IDLE, or while the final bit of the current word is on sout.
  assign w_ready  = (r_state == IDLE) || (r_cnt == LAST);
  assign w_accept = bus.din_valid && w_ready;

  // The shift register keeps the not-yet-sent bits aligned so the next bit
  // always sits at the same end (MSB end for MSB-first, LSB end otherwise).
  assign w_first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_load      = MSB_FIRST ? {bus.din[WIDTH-2:0], 1'b0}
                                 : {1'b0, bus.din[WIDTH-1:1]};
  assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[WIDTH-1:1]};

  // Control FSM with registered serial outputs; reset wins over a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
    end else if (w_accept) begin
      r_state      <= SHIFT;
      r_shift      <= w_load;
      r_cnt        <= '0;
      r_sout       <= w_first_bit;
      r_sout_valid <= 1'b1;
      r_last       <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (r_cnt != LAST) begin
        r_shift      <= w_shifted;
        r_cnt        <= r_cnt + 1'b1;
        r_sout       <= w_next_bit;
        r_sout_valid <= 1'b1;
        r_last       <= (r_cnt == LAST_M1);
      end else begin
        // Word finished with nothing waiting: drop back to an idle line.
        r_state      <= IDLE;
        r_shift      <= '0;
        r_sout       <= 1'b0;
        r_sout_valid <= 1'b0;
        r_last       <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.last_bit   = r_last;
  assign bus.busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances cover WIDTH=4 MSB-first,
// WIDTH=4 LSB-first and WIDTH=8 MSB-first.
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if4m ();
  piso_serializer_if #(.WIDTH(4)) if4l ();
  piso_serializer_if #(.WIDTH(8)) if8  ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (.clk(clk), .rst(rst), .bus(if4m));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (.clk(clk), .rst(rst), .bus(if4l));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8  (.clk(clk), .rst(rst), .bus(if8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {sout, sout_valid, last_bit, din_ready, busy} of the W4 MSB-first instance
  function automatic logic [4:0] st4m();
    return {if4m.sout, if4m.sout_valid, if4m.last_bit, if4m.din_ready, if4m.busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_run++;
    if (st4m() !== 5'b00010) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", st4m(), 5'b00010);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_s;
    logic [4:0] exp;
    exp_s = 4'b1100;
    if4m.din = 4'b1100; if4m.din_valid = 1'b1;
    tick();
    if4m.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {exp_s[3-i], 1'b1, (i == 3), (i == 3), 1'b1};
      n_run++;
      if (st4m() !== exp) begin
        n_fail++; $display("FAIL single bit%0d got=%b exp=%b", i, st4m(), exp);
      end
      tick();
    end
    n_run++;
    if (st4m() !== 5'b00010) begin
      n_fail++; $display("FAIL single_idle got=%b exp=%b", st4m(), 5'b00010);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_s;
    logic [4:0] exp;
    logic       edge_bit;
    exp_s = 8'b1100_0011;
    if4m.din = 4'b1100; if4m.din_valid = 1'b1;
    tick();
    if4m.din = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      edge_bit = (i == 3) || (i == 7);
      exp = {exp_s[7-i], 1'b1, edge_bit, edge_bit, 1'b1};
      n_run++;
      if (st4m() !== exp) begin
        n_fail++; $display("FAIL b2b bit%0d got=%b exp=%b", i, st4m(), exp);
      end
      tick();
      if (i == 3) if4m.din_valid = 1'b0;
    end
    n_run++;
    if (st4m() !== 5'b00010) begin
      n_fail++; $display("FAIL b2b_idle got=%b exp=%b", st4m(), 5'b00010);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_s;
    logic [1:0] got;
    exp_s = 4'b1011;  // 1101 sent LSB first: 1,0,1,1
    if4l.din = 4'b1101; if4l.din_valid = 1'b1;
    tick();
    if4l.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = {if4l.sout, if4l.sout_valid};
      n_run++;
      if (got !== {exp_s[3-i], 1'b1}) begin
        n_fail++; $display("FAIL lsb bit%0d got=%b exp=%b", i, got, {exp_s[3-i], 1'b1});
      end
      tick();
    end
    n_run++;
    if (if4l.sout_valid !== 1'b0) begin
      n_fail++; $display("FAIL lsb_idle got=%b exp=0", if4l.sout_valid);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp_s;
    logic [4:0] exp;
    logic       edge_bit;
    exp_s = 8'b1010_0101;
    if4m.din = 4'b1010; if4m.din_valid = 1'b1;
    tick();
    if4m.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge_bit = (i == 3) || (i == 7);
      exp = {exp_s[7-i], 1'b1, edge_bit, edge_bit, 1'b1};
      n_run++;
      if (st4m() !== exp) begin
        n_fail++; $display("FAIL ignore bit%0d got=%b exp=%b", i, st4m(), exp);
      end
      if (i == 0) begin if4m.din = 4'b0101; if4m.din_valid = 1'b1; end
      tick();
      if (i == 3) begin if4m.din_valid = 1'b0; if4m.din = 4'b1111; end
    end
    n_run++;
    if (st4m() !== 5'b00010) begin
      n_fail++; $display("FAIL ignore_idle got=%b exp=%b", st4m(), 5'b00010);
    end
  endtask

  task automatic test_reset_mid();
    if4m.din = 4'b1111; if4m.din_valid = 1'b1;
    tick();
    if4m.din_valid = 1'b0;
    tick();                 // second bit now on sout
    n_run++;
    if (st4m() !== 5'b11001) begin
      n_fail++; $display("FAIL rstmid_pre got=%b exp=%b", st4m(), 5'b11001);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (st4m() !== 5'b00010) begin
        n_fail++; $display("FAIL rstmid cyc%0d got=%b exp=%b", i, st4m(), 5'b00010);
      end
      tick();
    end
    // reset coincident with a handshake in IDLE drops the word
    if4m.din = 4'b1010; if4m.din_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; if4m.din_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (st4m() !== 5'b00010) begin
        n_fail++; $display("FAIL rst_vs_accept cyc%0d got=%b exp=%b", i, st4m(), 5'b00010);
      end
      tick();
    end
  endtask

  task automatic test_sweep_w8();
    logic [7:0] words [20];
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81;
    fork
      begin : drive
        for (int w = 0; w < 20; w++) begin
          int   gap;
          int   guard;
          logic acc;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) tick();
          if8.din = words[w]; if8.din_valid = 1'b1;
          guard = 0;
          do begin
            acc = if8.din_ready;
            tick();
            guard++;
          end while (!acc && guard < 50);
          if8.din_valid = 1'b0;
          if8.din = 8'($urandom);
        end
      end
      begin : watch
        logic [7:0] rec;
        int nbits;
        int got;
        int cyc;
        rec = '0; nbits = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 2000) begin
          tick();
          cyc++;
          if (if8.sout_valid) begin
            rec = {rec[6:0], if8.sout};
            nbits++;
            if (if8.last_bit) begin
              n_run++;
              if (rec !== words[got] || nbits != 8) begin
                n_fail++;
                $display("FAIL sweep word%0d got=%h/%0d bits exp=%h/8 bits",
                         got, rec, nbits, words[got]);
              end
              got++; nbits = 0;
            end
          end else if (if8.sout !== 1'b0) begin
            n_run++; n_fail++;
            $display("FAIL sweep_idle_level got=%b exp=0", if8.sout);
          end
        end
        n_run++;
        if (got != 20) begin
          n_fail++; $display("FAIL sweep_timeout got=%0d words exp=20", got);
        end
      end
    join
  endtask

  initial begin
    if4m.din = '0; if4m.din_valid = 1'b0;
    if4l.din = '0; if4l.din_valid = 1'b0;
    if8.din  = '0; if8.din_valid  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_ignore_busy();
    test_reset_mid();
    test_sweep_w8();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
